// File: rtl/mux_eight_pkg.sv
// +----------------------------------------------------------------------------+
// | mux_eight_pkg: shared sizes, FSM encoding and helpers for the mux_eight     |
// | arbiter slice.                                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mux_eight_pkg;

  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_eight.sv
// +----------------------------------------------------------------------------+
// | mux_eight: plain 8-to-1 select mux steered by the arbiter's sel output.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mux_eight #(
  parameter int W = 8
) (
  input  logic [W-1:0] I0,
  input  logic [W-1:0] I1,
  input  logic [W-1:0] I2,
  input  logic [W-1:0] I3,
  input  logic [W-1:0] I4,
  input  logic [W-1:0] I5,
  input  logic [W-1:0] I6,
  input  logic [W-1:0] I7,
  input  logic [2:0]   s,
  output logic [W-1:0] y
);

  always_comb begin
    y = I0;
    case (s)
      3'd0: y = I0;
      3'd1: y = I1;
      3'd2: y = I2;
      3'd3: y = I3;
      3'd4: y = I4;
      3'd5: y = I5;
      3'd6: y = I6;
      3'd7: y = I7;
      default: y = I0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rr_pick_eight.sv
// +----------------------------------------------------------------------------+
// | rr_pick_eight: rotating-priority search over eight requests, beginning at  |
// | index start and wrapping modulo 8.                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_pick_eight
  import mux_eight_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;

  // Walk from the farthest offset back to start so the nearest hit is written last.
  always_comb begin
    found  = 1'b0;
    idx    = start;
    w_cand = start;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_cand = start + SEL_W'(i);
      if (req[w_cand]) begin
        found = 1'b1;
        idx   = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_eight_arbiter.sv
// +----------------------------------------------------------------------------+
// | mux_eight_arbiter: round-robin owner selection with bounded hold time,     |
// | driving the select of mux_eight.                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mux_eight_arbiter
  import mux_eight_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int N_REQ    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic [HOLD_W-1:0] hold_cnt
);

  localparam logic [HOLD_W-1:0] C_MAX_HOLD = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

  state_t            r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_ptr,   w_ptr_nxt;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [SEL_W-1:0]  r_sel,   w_sel_nxt;
  logic              r_busy,  w_busy_nxt;
  logic [HOLD_W-1:0] r_hold,  w_hold_nxt;

  logic              w_owner_req;
  logic              w_at_max;
  logic [N_REQ-1:0]  w_pick_req;
  logic [SEL_W-1:0]  w_start;
  logic              w_found;
  logic [SEL_W-1:0]  w_idx;

  assign w_owner_req = req[r_ptr];
  assign w_at_max    = (r_hold >= C_MAX_HOLD);
  assign w_start     = r_ptr + SEL_W'(1);

  // While owning, the owner is excluded so a preempted owner cannot win itself back.
  assign w_pick_req  = (r_state == ST_OWN) ? (req & ~idx_to_onehot(r_ptr)) : req;

  rr_pick_eight u_pick (
    .req   (w_pick_req),
    .start (w_start),
    .found (w_found),
    .idx   (w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_hold_nxt  = r_hold;

    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_OWN;
          w_ptr_nxt   = w_idx;
          w_grant_nxt = idx_to_onehot(w_idx);
          w_sel_nxt   = w_idx;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = C_HOLD_ONE;
        end
      end

      ST_OWN: begin
        if (!w_owner_req || w_at_max) begin
          if (w_found) begin
            // Release or preemption hands over with no idle cycle.
            w_ptr_nxt   = w_idx;
            w_grant_nxt = idx_to_onehot(w_idx);
            w_sel_nxt   = w_idx;
            w_busy_nxt  = 1'b1;
            w_hold_nxt  = C_HOLD_ONE;
          end else if (!w_owner_req) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt  = C_MAX_HOLD;
          end
        end else begin
          w_hold_nxt = r_hold + C_HOLD_ONE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= SEL_W'(N_REQ - 1);
      r_grant <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign grant    = r_grant;
  assign sel      = r_sel;
  assign busy     = r_busy;
  assign hold_cnt = r_hold;

endmodule

`default_nettype wire

// File: tb/tb_mux_eight_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_mux_eight_arbiter: vector table and round-robin sequence for the        |
// | arbiter, with mux_eight output tracked against the expected select.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mux_eight_arbiter;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] hold;
  } vec_t;

  localparam logic [7:0] D_BASE = 8'hA0;

  logic       clk;
  logic       rst;
  logic [7:0] req, req1;
  logic [7:0] grant, grant1;
  logic [2:0] sel, sel1;
  logic       busy, busy1;
  logic [7:0] hold_cnt, hold_cnt1;
  logic [7:0] mux_y;

  int total = 0;
  int bad   = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  mux_eight_arbiter #(.MAX_HOLD(4), .N_REQ(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .sel      (sel),
    .busy     (busy),
    .hold_cnt (hold_cnt)
  );

  mux_eight_arbiter #(.MAX_HOLD(1), .N_REQ(8)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .req      (req1),
    .grant    (grant1),
    .sel      (sel1),
    .busy     (busy1),
    .hold_cnt (hold_cnt1)
  );

  mux_eight #(.W(8)) u_mux (
    .I0 (D_BASE + 8'd0),
    .I1 (D_BASE + 8'd1),
    .I2 (D_BASE + 8'd2),
    .I3 (D_BASE + 8'd3),
    .I4 (D_BASE + 8'd4),
    .I5 (D_BASE + 8'd5),
    .I6 (D_BASE + 8'd6),
    .I7 (D_BASE + 8'd7),
    .s  (sel),
    .y  (mux_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                     input logic [2:0] s, input logic b, input logic [7:0] h);
    vec_t v;
    v.rst = r; v.req = q; v.grant = g; v.sel = s; v.busy = b; v.hold = h;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t e;
    rst  = 1'b1;
    req  = 8'h00;
    req1 = 8'h00;

    // reset, single request, reset mid-grant
    add(1, 8'h00, 8'h00, 3'd0, 0, 8'd0);
    add(1, 8'h00, 8'h00, 3'd0, 0, 8'd0);
    add(0, 8'h04, 8'h04, 3'd2, 1, 8'd1);
    add(0, 8'h04, 8'h04, 3'd2, 1, 8'd2);
    add(1, 8'h04, 8'h00, 3'd0, 0, 8'd0);
    // preemption between 0 and 7
    add(0, 8'h81, 8'h01, 3'd0, 1, 8'd1);
    add(0, 8'h81, 8'h01, 3'd0, 1, 8'd2);
    add(0, 8'h81, 8'h01, 3'd0, 1, 8'd3);
    add(0, 8'h81, 8'h01, 3'd0, 1, 8'd4);
    add(0, 8'h81, 8'h80, 3'd7, 1, 8'd1);
    add(0, 8'h81, 8'h80, 3'd7, 1, 8'd2);
    add(0, 8'h81, 8'h80, 3'd7, 1, 8'd3);
    add(0, 8'h81, 8'h80, 3'd7, 1, 8'd4);
    add(0, 8'h81, 8'h01, 3'd0, 1, 8'd1);
    add(0, 8'h00, 8'h00, 3'd0, 0, 8'd0);
    // saturation with no contender
    add(0, 8'h20, 8'h20, 3'd5, 1, 8'd1);
    add(0, 8'h20, 8'h20, 3'd5, 1, 8'd2);
    add(0, 8'h20, 8'h20, 3'd5, 1, 8'd3);
    for (int k = 0; k < 7; k++) add(0, 8'h20, 8'h20, 3'd5, 1, 8'd4);
    // back-to-back release
    add(0, 8'h08, 8'h08, 3'd3, 1, 8'd1);
    add(0, 8'h28, 8'h08, 3'd3, 1, 8'd2);
    add(0, 8'h20, 8'h20, 3'd5, 1, 8'd1);
    add(0, 8'h00, 8'h00, 3'd5, 0, 8'd0);
    // wrap-around from owner 6
    add(0, 8'h40, 8'h40, 3'd6, 1, 8'd1);
    add(0, 8'h03, 8'h01, 3'd0, 1, 8'd1);
    add(0, 8'h02, 8'h02, 3'd1, 1, 8'd1);
    add(0, 8'h00, 8'h00, 3'd1, 0, 8'd0);
    add(0, 8'h00, 8'h00, 3'd1, 0, 8'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      req = vecs[i].req;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d grant", i), 32'(grant),    32'(e.grant));
      chk($sformatf("v%0d sel", i),   32'(sel),      32'(e.sel));
      chk($sformatf("v%0d busy", i),  32'(busy),     32'(e.busy));
      chk($sformatf("v%0d hold", i),  32'(hold_cnt), 32'(e.hold));
      chk($sformatf("v%0d mux_y", i), 32'(mux_y),    32'(D_BASE + 8'(e.sel)));
    end

    // MAX_HOLD=1: strict per-cycle rotation across all eight requesters
    for (int i = 0; i < 9; i++) begin
      vec_t v;
      @(negedge clk);
      req1 = 8'hFF;
      v.rst = 0; v.req = 8'hFF; v.sel = 3'(i % 8);
      v.grant = 8'h01 << (i % 8); v.busy = 1; v.hold = 8'd1;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("rr%0d sel", i),   32'(sel1),      32'(e.sel));
      chk($sformatf("rr%0d grant", i), 32'(grant1),    32'(e.grant));
      chk($sformatf("rr%0d hold", i),  32'(hold_cnt1), 32'(e.hold));
      chk($sformatf("rr%0d busy", i),  32'(busy1),     32'(e.busy));
    end
    @(negedge clk);
    req1 = 8'h00;
    @(posedge clk);
    #1;
    chk("rr_idle grant", 32'(grant1), 32'h0);
    chk("rr_idle busy",  32'(busy1),  32'h0);
    chk("rr_idle sel",   32'(sel1),   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mux_eight_arbiter.md
Name: mux_eight_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8-to-1 select mux (`mux_eight`).
- Eight requesters compete for the shared mux output. The block grants one owner at a time and drives the mux select port `s` with the owner's index.
- It enforces a bounded hold time so that no requester monopolises the mux.
- It sits between the requesting sources and `mux_eight`. Its `sel` output connects directly to `mux_eight.s`.

Parameters:
- MAX_HOLD, 4: maximum consecutive grant cycles for one owner while other requests are pending. Legal range 1..255.
- N_REQ, 8: number of requesters. Fixed at 8; it matches the mux inputs I0..I7.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous and active-high.
- req  input  8  request vector; bit k means requester k wants mux input Ik routed.
- grant  output  8  one-hot grant, registered; all-zero when no owner.
- sel  output  3  registered mux select = index of current owner; connects to `mux_eight.s`.
- busy  output  1  registered; high while an owner holds the mux.
- hold_cnt  output  8  registered count of cycles the current owner has held the grant. Saturates at MAX_HOLD.

Behaviour:
- Reset (rst=1 at a clock edge): grant=8'h00, sel=3'd0, busy=0, hold_cnt=0, state=IDLE, last-owner pointer ptr=3'd7 (so requester 0 has first priority). Reset overrides everything, including mid-grant: grant drops on the cycle after the reset edge.
- Priority search: scan req starting at index ptr+1, wrapping modulo 8. The first set bit wins. Indices are 3-bit unsigned, so wrap from 7 to 0 is natural overflow.
- States are IDLE and OWN.
- IDLE:
  - If req==0, stay in IDLE. Outputs hold, except that sel keeps its last value.
  - If any req bit is set, the winner w is registered at the next edge: grant=1<<w, sel=w, busy=1, hold_cnt=1, ptr=w, go to OWN.
  - Latency is one cycle from req visible to grant visible.
- OWN (owner o = ptr):
  - a) req[o]=0 (release):
    - If other requests are pending, re-arbitrate from o+1. The new winner is granted at the next edge with no idle gap, and hold_cnt=1.
    - Otherwise go to IDLE: grant=0, busy=0, hold_cnt=0, sel unchanged.
  - b) req[o]=1, hold_cnt<MAX_HOLD: keep the grant and increment hold_cnt.
  - c) req[o]=1, hold_cnt==MAX_HOLD, other request pending: preempt. Grant the next winner searching from o+1, with hold_cnt=1. Owner o must re-request and wait for its round-robin turn.
  - d) req[o]=1, hold_cnt==MAX_HOLD, no other request: keep the grant; hold_cnt stays at MAX_HOLD (saturating).
- Requests newly asserted in the same cycle as a release or preemption take part in that cycle's arbitration.
- grant is always one-hot or zero. sel == index of the set grant bit whenever busy=1.
- req is sampled only at clock edges. Glitches between edges have no effect.
- MAX_HOLD=1 degenerates to strict per-cycle round-robin among contending requesters.

Decomposition:
- Shared package (mux_eight_pkg):
  - N_REQ=8, SEL_W=3, HOLD_W=8.
  - State encoding constants ST_IDLE=1'b0, ST_OWN=1'b1.
- One combinational sub-module, rr_pick_eight:
  - Inputs: req[7:0], start[2:0].
  - Outputs: found, idx[2:0].
  - Rotating priority search, reused for initial grant, release and preemption.
- Top-level mux_eight_arbiter holds the registers and the FSM.
- The bench instantiates the arbiter together with `mux_eight` and checks that the mux result tracks I[sel].

Test Plan:
- Reset then single request: rst=1 for 2 cycles, then req=8'h04 → one cycle later grant=8'h04, sel=3'd2, busy=1, hold_cnt=1. rst=1 mid-grant → next cycle grant=0, busy=0, sel=0.
- Round-robin order: req=8'hFF held with MAX_HOLD=1 → sel sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles, with grant always one-hot.
- Preemption: req=8'h81, MAX_HOLD=4 → sel=0 for 4 cycles (hold_cnt 1..4), then sel=7 for 4 cycles, then sel=0.
- Saturation with no contender: req=8'h20 held for 10 cycles → grant=8'h20 throughout, hold_cnt rises 1,2,3,4 and then stays at 4.
- Back-to-back release: owner 3 drops req[3] while req[5]=1 → next edge grant=8'h20, sel=5, hold_cnt=1, busy stays high (no idle cycle). All requests drop → next edge grant=0, busy=0, sel stays 5.
- Wrap-around: ptr=6 (owner 6 releases) with req=8'h03 → grant goes to requester 0 (sel=0), then requester 1 after owner 0 releases.
